// File: rtl/tick_event_gen.sv
// tick_event_gen: turns upstream counter overflows into a ready/valid event stream with a saturating backlog.
// Optional TICK_EVT_MISS_CNT_EN adds a 16-bit dropped-event counter port miss_cnt.
module tick_event_gen #(
   parameter int WIDTH  = 32,
   parameter int PEND_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [WIDTH-1:0]  periods,
   input  logic              cnt_ovf,
   input  logic              evt_ready,
   output logic              evt_valid,
   output logic [WIDTH-1:0]  evt_seq,
   output logic [PEND_W-1:0] pend,
   output logic              busy,
`ifdef TICK_EVT_MISS_CNT_EN
   output logic [15:0]       miss_cnt,
`endif
   output logic              ovf_err
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] tick_q, tick_d, per_q, per_d, seq_q, seq_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic err_q, err_d, arm, acc, gen, sat, drop;
`ifdef TICK_EVT_MISS_CNT_EN
   logic [15:0] miss_q, miss_d;
`endif
   always_comb begin
      arm    = state_q == IDLE && start && !stop;
      acc    = state_q != IDLE && pend_q != '0 && evt_ready;
      gen    = state_q == RUN && !stop && cnt_ovf && tick_q == per_q - WIDTH'(1);
      sat    = &pend_q;
      drop   = gen && sat && !acc;
      // generate+accept together (saturated or not) leaves the backlog unchanged
      pend_d = arm ? '0 : (gen && !acc && !sat) ? pend_q + PEND_W'(1) :
               (acc && !gen) ? pend_q - PEND_W'(1) : pend_q;
      seq_d  = arm ? '0 : acc ? seq_q + WIDTH'(1) : seq_q;
      err_d  = !arm && (err_q || drop);
      per_d  = arm ? (periods == '0 ? WIDTH'(1) : periods) : per_q;
      tick_d = (state_q != RUN || stop || gen) ? '0 : cnt_ovf ? tick_q + WIDTH'(1) : tick_q;
      state_d = arm ? RUN :
                (state_q == RUN && stop) ? (pend_d != '0 ? DRAIN : IDLE) :
                (state_q == DRAIN && pend_d == '0) ? IDLE : state_q;
`ifdef TICK_EVT_MISS_CNT_EN
      miss_d = arm ? '0 : (drop && miss_q != 16'hFFFF) ? miss_q + 16'd1 : miss_q;
`endif
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         tick_q  <= '0;
         per_q   <= WIDTH'(1);
         seq_q   <= '0;
         pend_q  <= '0;
         err_q   <= 1'b0;
`ifdef TICK_EVT_MISS_CNT_EN
         miss_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         per_q   <= per_d;
         seq_q   <= seq_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
`ifdef TICK_EVT_MISS_CNT_EN
         miss_q  <= miss_d;
`endif
      end
   end
   assign evt_valid = pend_q != '0;
   assign evt_seq   = seq_q;
   assign pend      = pend_q;
   assign busy      = state_q != IDLE;
   assign ovf_err   = err_q;
`ifdef TICK_EVT_MISS_CNT_EN
   assign miss_cnt  = miss_q;
`endif
endmodule
